nios_system_sysid_regs: RTL and testbench

//  Parametrised system-ID / housekeeping register slave on the Nios II Avalon-MM bus.

---
 rtl/nios_system_sysid_regs.sv | 130 +++++++++++++
 tb/tb_nios_system_sysid_regs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_regs.sv
// System-ID / housekeeping Avalon-MM slave: ID, build timestamp, uptime counter
// with a coherent hi/lo snapshot, scratch word, control and user status words.
module nios_system_sysid_regs #(
    parameter logic [31:0] SYS_ID      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1346454016,
    parameter int          CNT_W       = 64,
    parameter int          NUM_USER    = 2,
    parameter logic        CTRL_EN_RST = 1'b1
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic [2:0]                                    address,
    input  logic                                          chipselect,
    input  logic                                          read,
    input  logic                                          write,
    input  logic [31:0]                                   writedata,
    input  logic [3:0]                                    byteenable,
    input  logic [(NUM_USER == 0 ? 1 : 32*NUM_USER)-1:0]  user_status,
    output logic [31:0]                                   readdata,
    output logic                                          readdatavalid
);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_UP_LO   = 3'd2;
    localparam logic [2:0] ADDR_UP_HI   = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_CONTROL = 3'd5;
    localparam logic [2:0] ADDR_USER0   = 3'd6;
    localparam logic [2:0] ADDR_USER1   = 3'd7;

    // Bus handshake: a read is accepted when chipselect & read, and its data is
    // returned with readdatavalid exactly one cycle later; there is no wait state.
    // A write is accepted when chipselect & write and takes effect on that edge.
    logic rd;
    logic wr;
    logic lo_read;
    logic ctrl_wr;
    logic clr_req;

    logic [CNT_W-1:0]    counter;
    logic [CNT_W-33:0]   hi_shadow;
    logic [31:0]         scratch;
    logic                en;
    logic [31:0]         hi_ext;
    logic [31:0]         user_word [2];
    logic [31:0]         rdata_next;

    assign rd      = chipselect & read;
    assign wr      = chipselect & write;
    assign lo_read = rd && (address == ADDR_UP_LO);
    assign ctrl_wr = wr && (address == ADDR_CONTROL) && byteenable[0];
    assign clr_req = ctrl_wr && writedata[1];
    assign hi_ext  = 32'(hi_shadow);

    for (genvar k = 0; k < 2; k++) begin : g_user
        if (k < NUM_USER) begin : g_present
            assign user_word[k] = user_status[32*k +: 32];
        end else begin : g_absent
            assign user_word[k] = 32'h0;
        end
    end

    always_comb begin
        rdata_next = 32'h0;
        case (address)
            ADDR_ID:      rdata_next = SYS_ID;
            ADDR_TSTAMP:  rdata_next = TIMESTAMP;
            ADDR_UP_LO:   rdata_next = counter[31:0];
            ADDR_UP_HI:   rdata_next = hi_ext;
            ADDR_SCRATCH: rdata_next = scratch;
            ADDR_CONTROL: rdata_next = {31'h0, en};
            ADDR_USER0:   rdata_next = user_word[0];
            ADDR_USER1:   rdata_next = user_word[1];
            default:      rdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= rd;
            if (rd) begin
                readdata <= rdata_next;
            end
        end
    end

    // Clear wins over increment, whatever en value is written alongside it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (clr_req) begin
            counter <= '0;
        end else if (en) begin
            counter <= counter + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_shadow <= '0;
        end else if (lo_read) begin
            hi_shadow <= counter[CNT_W-1:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en <= CTRL_EN_RST;
        end else if (ctrl_wr) begin
            en <= writedata[0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= 32'h0;
        end else if (wr && (address == ADDR_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_regs.sv
// Bench for nios_system_sysid_regs: directed steps then random traffic, checked
// against a count-from-base model of the register map.
module tb_nios_system_sysid_regs;

    localparam logic [31:0] SYS_ID    = 32'hC0DE_1234;
    localparam logic [31:0] TIMESTAMP = 32'd1346454016;

    logic        clock;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [63:0] user_status;
    logic [31:0] readdata;
    logic        readdatavalid;

    nios_system_sysid_regs #(
        .SYS_ID(SYS_ID), .TIMESTAMP(TIMESTAMP), .CNT_W(64), .NUM_USER(2), .CTRL_EN_RST(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .user_status(user_status), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // model: counter value = m_base + cycles elapsed since m_cyc0 while enabled
    int unsigned cyc;
    int unsigned m_cyc0;
    logic [63:0] m_base;
    logic        m_en;
    logic [31:0] m_hi;
    logic [31:0] m_scratch;
    logic [31:0] last_rdata;
    logic [31:0] exp_q[$];
    int          errors;
    int          checks;
    logic [31:0] rv;
    logic [31:0] rv2;

    function automatic logic [63:0] cur_count();
        return m_en ? m_base + 64'(cyc - m_cyc0) : m_base;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [63:0] c;
        c = cur_count();
        case (a)
            3'd0:    return SYS_ID;
            3'd1:    return TIMESTAMP;
            3'd2:    return c[31:0];
            3'd3:    return m_hi;
            3'd4:    return m_scratch;
            3'd5:    return {31'h0, m_en};
            3'd6:    return user_status[31:0];
            default: return user_status[63:32];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_cyc0     = 0;
        m_base     = 64'h0;
        m_en       = 1'b1;
        m_hi       = 32'h0;
        m_scratch  = 32'h0;
        last_rdata = 32'h0;
        exp_q.delete();
    endtask

    // driver: one bus cycle with optional read and/or write, checked on the next negedge
    task automatic bus_op(input string tag, input logic r, input logic w, input logic [2:0] a,
                          input logic [31:0] wd, input logic [3:0] be, output logic [31:0] data);
        logic [63:0] c;
        chipselect = 1'b1; read = r; write = w; address = a; writedata = wd; byteenable = be;
        if (r) begin
            exp_q.push_back(model_read(a));
            if (a == 3'd2) begin
                c    = cur_count();
                m_hi = c[63:32];
            end
        end
        if (w && a == 3'd4) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
        end
        if (w && a == 3'd5 && be[0]) begin
            c      = cur_count();
            m_base = wd[1] ? 64'h0 : (m_en ? c + 64'd1 : c);
            m_cyc0 = cyc + 1;
            m_en   = wd[0];
        end
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        data = readdata;
        if (r) begin
            check({tag, "_valid"}, 32'(readdatavalid), 32'h1);
            last_rdata = exp_q.pop_front();
            check(tag, readdata, last_rdata);
        end else begin
            check({tag, "_novalid"}, 32'(readdatavalid), 32'h0);
            check({tag, "_hold"}, readdata, last_rdata);
        end
    endtask

    task automatic rd_op(input string tag, input logic [2:0] a, output logic [31:0] data);
        bus_op(tag, 1'b1, 1'b0, a, 32'h0, 4'h0, data);
    endtask

    task automatic wr_op(input string tag, input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] dummy;
        bus_op(tag, 1'b0, 1'b1, a, wd, be, dummy);
    endtask

    task automatic idle(input int n);
        logic [31:0] dummy;
        for (int i = 0; i < n; i++) bus_op("idle", 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, dummy);
    endtask

    task automatic force_count(input logic [63:0] v);
        force dut.counter = v;
        #1;
        release dut.counter;
        m_base = v;
        m_cyc0 = cyc;
    endtask

    initial begin
        errors = 0; checks = 0;
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'h0; byteenable = 4'h0;
        user_status = 64'h1111_2222_3333_4444;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(readdatavalid), 32'h0);
        check("rst_data", readdata, 32'h0);
        reset_n = 1'b1;

        // ID and timestamp back-to-back
        rd_op("id", 3'd0, rv);
        check("id_const", rv, SYS_ID);
        rd_op("tstamp", 3'd1, rv);
        check("tstamp_const", rv, 32'd1346454016);
        idle(2);

        // scratch byte lanes and RO write
        wr_op("scr_wr", 3'd4, 32'hA5A5_A5A5, 4'b0101);
        rd_op("scr_rd", 3'd4, rv);
        check("scr_const", rv, 32'h00A5_00A5);
        wr_op("id_wr", 3'd0, 32'hFFFF_FFFF, 4'hF);
        rd_op("id_after_wr", 3'd0, rv);
        bus_op("scr_rw", 1'b1, 1'b1, 3'd4, 32'h1234_5678, 4'hF, rv);
        check("scr_rw_old", rv, 32'h00A5_00A5);
        rd_op("scr_new", 3'd4, rv);

        // snapshot: LO then HI returns shadow, not live
        force_count(64'h0000_0000_FFFF_FFFF);
        rd_op("snap_lo", 3'd2, rv);
        check("snap_lo_const", rv, 32'hFFFF_FFFF);
        idle(10);
        rd_op("snap_hi", 3'd3, rv);
        check("snap_hi_const", rv, 32'h0);
        rd_op("snap_lo2", 3'd2, rv);
        rd_op("snap_hi2", 3'd3, rv);
        check("snap_hi2_const", rv, 32'h1);

        // enable off, hold, then clear+enable
        wr_op("ctl_off", 3'd5, 32'h0, 4'h1);
        idle(20);
        rd_op("hold_lo1", 3'd2, rv);
        idle(3);
        rd_op("hold_lo2", 3'd2, rv2);
        rd_op("ctl_rd0", 3'd5, rv);
        wr_op("ctl_clr_en", 3'd5, 32'h3, 4'h1);
        rd_op("clr_lo", 3'd2, rv);
        check("clr_small", 32'(rv <= 32'd3), 32'h1);
        idle(5);
        rd_op("resume_lo", 3'd2, rv);
        wr_op("ctl_noben", 3'd5, 32'h2, 4'h2);
        rd_op("noben_lo", 3'd2, rv);

        // full-width wrap, and LO read just before a clear
        force_count(64'hFFFF_FFFF_FFFF_FFFF);
        rd_op("wrap_lo1", 3'd2, rv);
        check("wrap_lo1_const", rv, 32'hFFFF_FFFF);
        rd_op("wrap_hi1", 3'd3, rv);
        check("wrap_hi1_const", rv, 32'hFFFF_FFFF);
        rd_op("wrap_lo2", 3'd2, rv);
        check("wrap_lo2_const", rv, 32'h1);
        rd_op("wrap_hi2", 3'd3, rv);
        check("wrap_hi2_const", rv, 32'h0);
        idle(4);
        rd_op("preclr_lo", 3'd2, rv);
        wr_op("clr_keep_off", 3'd5, 32'h2, 4'h1);
        bus_op("ctl_rw", 1'b1, 1'b1, 3'd5, 32'h1, 4'h1, rv);
        rd_op("postclr_lo", 3'd2, rv);

        // user words
        user_status = {$urandom, $urandom};
        rd_op("user0", 3'd6, rv);
        user_status = {$urandom, $urandom};
        rd_op("user1", 3'd7, rv);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic        r;
            logic        w;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            r  = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            if (a == 3'd5) begin
                wd[1] = ($urandom_range(0, 7) == 0);
                wd[0] = ($urandom_range(0, 3) != 0);
            end
            user_status = {$urandom, $urandom};
            bus_op("rand", r, w, a, wd, 4'($urandom_range(0, 15)), rv);
        end

        // reset in the cycle after an accepted read
        wr_op("pre_rst_scr", 3'd4, 32'hDEAD_BEEF, 4'hF);
        wr_op("pre_rst_ctl", 3'd5, 32'h0, 4'h1);
        chipselect = 1'b1; read = 1'b1; address = 3'd4;
        @(posedge clock);
        #1;
        chipselect = 1'b0; read = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(readdatavalid), 32'h0);
        check("midrst_data", readdata, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        idle(2);
        rd_op("post_rst_scr", 3'd4, rv);
        check("post_rst_scr_const", rv, 32'h0);
        rd_op("post_rst_ctl", 3'd5, rv);
        check("post_rst_ctl_const", rv, 32'h1);
        rd_op("post_rst_hi", 3'd3, rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
